// File: rtl/altmemddr_burst_pipeline_bridge.sv
// Avalon-MM pipeline bridge between the system interconnect and the DDR controller port.
// Commands are queued in a show-ahead CMD FIFO; read data returns through a credit-gated RSP FIFO.
module altmemddr_burst_pipeline_bridge #(
    parameter int  DATA_W    = 32,
    parameter int  ADDR_W    = 24,
    parameter int  BURST_W   = 4,
    parameter int  CMD_DEPTH = 4,
    parameter int  RSP_DEPTH = 16,
    localparam int BE_W      = DATA_W / 8,
    localparam int BE_LOG    = $clog2(BE_W),
    localparam int CRED_W    = $clog2(RSP_DEPTH) + 1
) (
    input  logic                     slave_clk,
    input  logic                     slave_reset_n,
    input  logic [ADDR_W-1:0]        slave_address,
    input  logic [BE_W-1:0]          slave_byteenable,
    input  logic [BURST_W-1:0]       slave_burstcount,
    input  logic                     slave_read,
    input  logic                     slave_write,
    input  logic [DATA_W-1:0]        slave_writedata,
    output logic                     slave_waitrequest,
    output logic [DATA_W-1:0]        slave_readdata,
    output logic                     slave_readdatavalid,
    output logic [ADDR_W+BE_LOG-1:0] master_address,
    output logic [BE_W-1:0]          master_byteenable,
    output logic [BURST_W-1:0]       master_burstcount,
    output logic                     master_read,
    output logic                     master_write,
    output logic [DATA_W-1:0]        master_writedata,
    input  logic                     master_waitrequest,
    input  logic [DATA_W-1:0]        master_readdata,
    input  logic                     master_readdatavalid,
    output logic                     protocol_err,
    output logic                     rsp_overflow,
    output logic [CRED_W-1:0]        reads_reserved
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int CMD_CW = CMD_AW + 1;
    localparam int RSP_CW = RSP_AW + 1;
    localparam int SUM_W  = CRED_W + 1;
    localparam logic [CMD_CW-1:0]  CMD_FULL = CMD_CW'(CMD_DEPTH);
    localparam logic [RSP_CW-1:0]  RSP_FULL = RSP_CW'(RSP_DEPTH);
    localparam logic [SUM_W-1:0]   CRED_MAX = SUM_W'(RSP_DEPTH);
    localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0]  wdata;
        logic [ADDR_W-1:0]  addr;
        logic [BE_W-1:0]    be;
        logic [BURST_W-1:0] burst;
        logic               rd;
        logic               wr;
    } cmd_t;

    cmd_t               cmd_mem [CMD_DEPTH];
    cmd_t               cmd_in;
    cmd_t               cmd_head;
    logic [CMD_AW-1:0]  cmd_wr_ptr, cmd_rd_ptr;
    logic [CMD_CW-1:0]  cmd_count;
    logic               cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [BURST_W-1:0] wbeats_left;
    logic               bad_cmd;
    logic               rd_fits, rd_issue;

    logic [DATA_W-1:0]  rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0]  rsp_wr_ptr, rsp_rd_ptr;
    logic [RSP_CW-1:0]  rsp_count;
    logic               rsp_full, rsp_empty, rsp_drop, rsp_push, rsp_pop;

    // ---------------- slave side / command queue ----------------
    assign cmd_full          = (cmd_count == CMD_FULL);
    assign cmd_empty         = (cmd_count == '0);
    assign slave_waitrequest = cmd_full;
    assign cmd_push          = (slave_read | slave_write) & ~cmd_full;

    // A simultaneous read+write becomes a write; a zero burst becomes a single beat.
    always_comb begin
        cmd_in.wdata = slave_writedata;
        cmd_in.addr  = slave_address;
        cmd_in.be    = slave_byteenable;
        cmd_in.burst = (slave_burstcount == '0) ? ONE_BEAT : slave_burstcount;
        cmd_in.rd    = slave_read & ~slave_write;
        cmd_in.wr    = slave_write;
    end

    assign bad_cmd = (slave_read & slave_write) | (slave_burstcount == '0) |
                     (slave_read & ~slave_write & (wbeats_left != '0));

    // NOTE: FIFO storage carries no reset; validity is tracked by the reset pointers and counts.
    always_ff @(posedge slave_clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= cmd_in;
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= master_readdata;
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            cmd_wr_ptr   <= '0;
            cmd_rd_ptr   <= '0;
            cmd_count    <= '0;
            wbeats_left  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CMD_AW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CMD_AW'(1);
            cmd_count <= cmd_count + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
            if (cmd_push & slave_write)
                wbeats_left <= (wbeats_left == '0) ? cmd_in.burst - ONE_BEAT
                                                   : wbeats_left - ONE_BEAT;
            if (cmd_push & bad_cmd) protocol_err <= 1'b1;
        end
    end

    // ---------------- master side (show-ahead head) ----------------
    assign cmd_head          = cmd_mem[cmd_rd_ptr];
    assign rd_fits           = (SUM_W'(reads_reserved) + SUM_W'(cmd_head.burst)) <= CRED_MAX;
    assign master_write      = ~cmd_empty & cmd_head.wr;
    assign master_read       = ~cmd_empty & cmd_head.rd & rd_fits;
    assign master_address    = {cmd_head.addr, {BE_LOG{1'b0}}};
    assign master_byteenable = cmd_head.be;
    assign master_burstcount = cmd_head.burst;
    assign master_writedata  = cmd_head.wdata;
    assign rd_issue          = master_read & ~master_waitrequest;
    assign cmd_pop           = (master_read | master_write) & ~master_waitrequest;

    // ---------------- response queue and read credits ----------------
    assign rsp_full  = (rsp_count == RSP_FULL);
    assign rsp_empty = (rsp_count == '0);
    assign rsp_drop  = master_readdatavalid & (rsp_full | (reads_reserved == '0));
    assign rsp_push  = master_readdatavalid & ~rsp_drop;
    assign rsp_pop   = ~rsp_empty;

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            rsp_wr_ptr          <= '0;
            rsp_rd_ptr          <= '0;
            rsp_count           <= '0;
            reads_reserved      <= '0;
            rsp_overflow        <= 1'b0;
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RSP_AW'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RSP_AW'(1);
            rsp_count <= rsp_count + RSP_CW'(rsp_push) - RSP_CW'(rsp_pop);
            // Credits cover both in-flight beats and beats parked in the RSP FIFO.
            reads_reserved <= reads_reserved
                              + (rd_issue ? CRED_W'(cmd_head.burst) : '0)
                              - CRED_W'(rsp_pop);
            if (rsp_drop) rsp_overflow <= 1'b1;
            slave_readdatavalid <= rsp_pop;
            if (rsp_pop) slave_readdata <= rsp_mem[rsp_rd_ptr];
        end
    end

endmodule

// File: tb/tb_altmemddr_burst_pipeline_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every cycle against
// a transaction-level model (command queue, credit arithmetic, DDR responder, expected read data).
module tb_altmemddr_burst_pipeline_bridge;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 24;
    localparam int BURST_W   = 4;
    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 16;

    logic        slave_clk = 1'b0;
    logic        slave_reset_n;
    logic [23:0] slave_address;
    logic [3:0]  slave_byteenable;
    logic [3:0]  slave_burstcount;
    logic        slave_read, slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [25:0] master_address;
    logic [3:0]  master_byteenable;
    logic [3:0]  master_burstcount;
    logic        master_read, master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        protocol_err, rsp_overflow;
    logic [4:0]  reads_reserved;

    altmemddr_burst_pipeline_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
        .slave_address(slave_address), .slave_byteenable(slave_byteenable),
        .slave_burstcount(slave_burstcount), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid), .master_address(master_address),
        .master_byteenable(master_byteenable), .master_burstcount(master_burstcount),
        .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
        .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
        .protocol_err(protocol_err), .rsp_overflow(rsp_overflow),
        .reads_reserved(reads_reserved)
    );

    always #5 slave_clk = ~slave_clk;

    typedef struct {
        logic [25:0] addr;
        logic [3:0]  be;
        logic [3:0]  bc;
        bit          rd;
        bit          wr;
        logic [31:0] data;
    } exp_cmd_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ddr_beat_t;

    typedef struct {
        int          vis;
        logic [31:0] data;
    } exp_rsp_t;

    exp_cmd_t  cmd_q [$];
    ddr_beat_t ddr_q [$];
    exp_rsp_t  exp_q [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int issued = 0;
    int delivered = 0;
    int wb_left = 0;
    int last_due = 0;
    int ddr_delay = 2;
    bit ddr_rand = 0;
    bit stall_force = 0;
    bit stall_rand = 0;
    bit perr_e = 0;
    bit ovf_e = 0;
    bit s_acc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: model the edge about to happen, then check the state it produced.
    task automatic tick();
        exp_cmd_t  h, e;
        ddr_beat_t b;
        exp_rsp_t  r;
        int        res_m, first, dly;
        bit        full_m, fits;
        #1;
        s_acc = 1'b0;
        if (!slave_reset_n) begin
            cmd_q.delete();
            exp_q.delete();
            issued = 0; delivered = 0; wb_left = 0;
            perr_e = 1'b0; ovf_e = 1'b0;
            check("rst_mread", master_read, 0);
            check("rst_mwrite", master_write, 0);
            check("rst_swait", slave_waitrequest, 0);
        end else begin
            res_m  = issued - delivered;
            full_m = (cmd_q.size() == CMD_DEPTH);
            check("s_waitreq", slave_waitrequest, full_m);
            if (cmd_q.size() == 0) begin
                check("m_read_idle", master_read, 0);
                check("m_write_idle", master_write, 0);
            end else begin
                h    = cmd_q[0];
                fits = (res_m + int'(h.bc)) <= RSP_DEPTH;
                check("m_write", master_write, h.wr);
                check("m_read", master_read, h.rd && fits);
                check("m_addr", master_address, h.addr);
                check("m_be", master_byteenable, h.be);
                check("m_bc", master_burstcount, h.bc);
                if (h.wr) check("m_wdata", master_writedata, h.data);
                if ((h.wr || (h.rd && fits)) && !master_waitrequest) begin
                    void'(cmd_q.pop_front());
                    if (h.rd) begin
                        issued += int'(h.bc);
                        dly   = ddr_rand ? int'($urandom_range(1, 12)) : ddr_delay;
                        first = cyc + 1 + dly;
                        if (first <= last_due) first = last_due + 1;
                        for (int i = 0; i < int'(h.bc); i++) begin
                            b.due  = first + i;
                            b.data = $urandom;
                            ddr_q.push_back(b);
                        end
                        last_due = first + int'(h.bc) - 1;
                    end
                end
            end
            if (master_readdatavalid) begin
                if (res_m == 0) ovf_e = 1'b1;
                else begin
                    r.vis  = cyc + 2;
                    r.data = master_readdata;
                    exp_q.push_back(r);
                end
            end
            if ((slave_read || slave_write) && !full_m) begin
                s_acc  = 1'b1;
                e.addr = {slave_address, 2'b00};
                e.be   = slave_byteenable;
                e.bc   = (slave_burstcount == 4'd0) ? 4'd1 : slave_burstcount;
                e.wr   = slave_write;
                e.rd   = slave_read && !slave_write;
                e.data = slave_writedata;
                if ((slave_read && slave_write) || slave_burstcount == 4'd0 || (e.rd && wb_left != 0))
                    perr_e = 1'b1;
                if (e.wr) wb_left = (wb_left == 0) ? int'(e.bc) - 1 : wb_left - 1;
                cmd_q.push_back(e);
            end
        end
        @(posedge slave_clk);
        cyc++;
        @(negedge slave_clk);
        if (slave_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) check("rdv_unexpected", slave_readdatavalid, 0);
            else begin
                r = exp_q.pop_front();
                check("rd_data", slave_readdata, r.data);
                check("rd_latency", cyc, r.vis);
                delivered++;
            end
        end else if (exp_q.size() > 0 && exp_q[0].vis <= cyc) begin
            check("rdv_missing", slave_readdatavalid, 1);
            void'(exp_q.pop_front());
            delivered++;
        end
        check("reserved", reads_reserved, issued - delivered);
        check("perr", protocol_err, perr_e);
        check("ovf", rsp_overflow, ovf_e);
        master_waitrequest = stall_force || (stall_rand && $urandom_range(0, 3) == 0);
        if (ddr_q.size() > 0 && ddr_q[0].due <= cyc + 1) begin
            b = ddr_q.pop_front();
            master_readdatavalid = 1'b1;
            master_readdata      = b.data;
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
        end
    endtask

    task automatic slave_cmd(input bit rd, input bit wr, input logic [23:0] addr,
                             input logic [3:0] be, input logic [3:0] bc, input logic [31:0] data);
        int n = 0;
        slave_read = rd; slave_write = wr; slave_address = addr;
        slave_byteenable = be; slave_burstcount = bc; slave_writedata = data;
        do begin
            tick();
            n++;
        end while (!s_acc && n < 200);
        if (!s_acc) check("cmd_accept_timeout", 0, 1);
        slave_read = 1'b0; slave_write = 1'b0;
    endtask

    task automatic wr_burst(input logic [23:0] addr, input logic [3:0] bc);
        for (int i = 0; i < int'(bc); i++)
            slave_cmd(0, 1, addr + 24'(i), 4'($urandom), bc, $urandom);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((cmd_q.size() != 0 || ddr_q.size() != 0 || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        bit          any_rdv;
        logic [25:0] snap_addr;
        logic [31:0] snap_data;

        slave_reset_n = 1'b0;
        slave_address = '0; slave_byteenable = '0; slave_burstcount = '0;
        slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;

        repeat (3) tick();
        check("reset_rdv", slave_readdatavalid, 0);
        check("reset_rdata", slave_readdata, 0);
        check("reset_swait", slave_waitrequest, 0);
        check("reset_perr", protocol_err, 0);
        check("reset_ovf", rsp_overflow, 0);
        check("reset_reserved", reads_reserved, 0);
        slave_reset_n = 1'b1;
        tick();

        // 1: single write forwarded one cycle after acceptance
        slave_cmd(0, 1, 24'h000010, 4'hF, 4'd1, 32'hDEADBEEF);
        check("t1_mwrite", master_write, 1);
        check("t1_maddr", master_address, 26'h0000040);
        check("t1_wdata", master_writedata, 32'hDEADBEEF);
        check("t1_bc", master_burstcount, 1);
        wait_idle(50);

        // 2: 8-beat read, DDR answers 2 cycles after accept
        ddr_delay = 2;
        slave_cmd(1, 0, 24'h000020, 4'hF, 4'd8, 32'h0);
        tick();
        check("t2_reserved8", reads_reserved, 8);
        wait_idle(100);
        check("t2_reserved0", reads_reserved, 0);

        // 3: three back-to-back 8-beat reads, slow DDR -> third issue stalls on credits
        ddr_delay = 20;
        slave_cmd(1, 0, 24'h000100, 4'hF, 4'd8, 32'h0);
        slave_cmd(1, 0, 24'h000200, 4'hF, 4'd8, 32'h0);
        slave_cmd(1, 0, 24'h000300, 4'hF, 4'd8, 32'h0);
        check("t3_stall", master_read, 0);
        check("t3_res16", reads_reserved, 16);
        wait_idle(300);
        check("t3_ovf", rsp_overflow, 0);

        // 4: master stalled 10 cycles while the slave keeps writing
        stall_force = 1'b1;
        master_waitrequest = 1'b1;
        k = 0;
        snap_addr = '0; snap_data = '0;
        for (int i = 0; i < 10; i++) begin
            slave_write = 1'b1; slave_read = 1'b0;
            slave_address = 24'h000400 + 24'(k); slave_byteenable = 4'hF;
            slave_burstcount = 4'd1; slave_writedata = 32'hA5A50000 + 32'(k);
            tick();
            if (s_acc) k++;
            if (i == 0) begin
                snap_addr = master_address;
                snap_data = master_writedata;
            end
        end
        slave_write = 1'b0;
        check("t4_accepts", k, 4);
        check("t4_swait", slave_waitrequest, 1);
        check("t4_hold_addr", master_address, snap_addr);
        check("t4_hold_data", master_writedata, snap_data);
        stall_force = 1'b0;
        master_waitrequest = 1'b0;
        wait_idle(50);

        // Randomized traffic: random bursts, DDR latency and master stalls
        stall_rand = 1'b1;
        ddr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                slave_cmd(1, 0, 24'($urandom), 4'($urandom), 4'($urandom_range(1, 8)), 32'h0);
            else
                wr_burst(24'($urandom), 4'($urandom_range(1, 8)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_idle(2000);
        stall_rand = 1'b0;
        ddr_rand = 1'b0;
        master_waitrequest = 1'b0;
        check("rand_ovf", rsp_overflow, 0);

        // 5: read+write together with burstcount 0 -> single write, burst 1, protocol error
        slave_cmd(1, 1, 24'h000500, 4'h3, 4'd0, 32'hCAFE0005);
        check("t5_perr", protocol_err, 1);
        check("t5_mwrite", master_write, 1);
        check("t5_mread", master_read, 0);
        check("t5_bc", master_burstcount, 1);
        wait_idle(50);

        // 6: reset with 4 reads outstanding; late beats are dropped
        ddr_delay = 15;
        slave_cmd(1, 0, 24'h000600, 4'hF, 4'd4, 32'h0);
        tick();
        check("t6_res4", reads_reserved, 4);
        slave_reset_n = 1'b0;
        tick();
        tick();
        check("t6_mread", master_read, 0);
        check("t6_mwrite", master_write, 0);
        check("t6_rdv", slave_readdatavalid, 0);
        check("t6_rdata", slave_readdata, 0);
        check("t6_perr", protocol_err, 0);
        check("t6_res0", reads_reserved, 0);
        slave_reset_n = 1'b1;
        any_rdv = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (slave_readdatavalid !== 1'b0) any_rdv = 1'b1;
        end
        check("t6_ovf", rsp_overflow, 1);
        check("t6_no_rdv", any_rdv, 0);
        check("t6_res_after", reads_reserved, 0);

        // 7: read arriving inside a write burst is queued but flags a protocol error
        ddr_delay = 3;
        slave_cmd(0, 1, 24'h000700, 4'hF, 4'd4, 32'h11110000);
        slave_cmd(1, 0, 24'h000800, 4'hF, 4'd1, 32'h0);
        check("t7_perr", protocol_err, 1);
        slave_cmd(0, 1, 24'h000701, 4'hF, 4'd4, 32'h11110001);
        slave_cmd(0, 1, 24'h000702, 4'hF, 4'd4, 32'h11110002);
        slave_cmd(0, 1, 24'h000703, 4'hF, 4'd4, 32'h11110003);
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
